// File: rtl/mux_scan_ctrl_if.sv
// Purpose : handshake/bus bundle between a scan master and mux_scan_ctrl.
// Latency : n/a (wires only).
// Backpr. : none; start is a level sampled by the controller only while idle.
// Ports   : start/cont/stop/dwell (and dir when MUX_SCAN_REVERSE_EN is defined)
//           from master; sel/data/strobe/busy/done back from the controller.
interface mux_scan_ctrl_if #(
    parameter int DWELL_W = 8
);
    logic               start;
    logic               cont;
    logic               stop;
    logic [DWELL_W-1:0] dwell;
`ifdef MUX_SCAN_REVERSE_EN
    logic               dir;
`endif
    logic [1:0]         sel;
    logic [5:2]         data;
    logic               strobe;
    logic               busy;
    logic               done;

`ifdef MUX_SCAN_REVERSE_EN
    modport master (output start, cont, stop, dwell, dir,
                    input  sel, data, strobe, busy, done);
    modport slave  (input  start, cont, stop, dwell, dir,
                    output sel, data, strobe, busy, done);
`else
    modport master (output start, cont, stop, dwell,
                    input  sel, data, strobe, busy, done);
    modport slave  (input  start, cont, stop, dwell,
                    output sel, data, strobe, busy, done);
`endif
endinterface

// File: rtl/mux_scan_ctrl.sv
// Purpose : sweeps a 4-way mux bank, holding each channel for dwell cycles,
//           optionally looping until stop; MUX_SCAN_REVERSE_EN adds a dir input.
// Latency : sel/strobe/busy update the edge after start; done one edge after last dwell.
// Backpr. : none; start is ignored while busy or in the done cycle.
// Ports   : clk, rst (sync, active-high), bus (mux_scan_ctrl_if.slave).
module mux_scan_ctrl #(
    parameter int DWELL_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    mux_scan_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [DWELL_W-1:0] ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_n;
    logic [1:0]         sel_q, sel_n;
    logic [5:2]         data_q, data_n;
    logic               strobe_q, strobe_n;
    logic               busy_q, busy_n;
    logic               done_q, done_n;
    logic [DWELL_W-1:0] cnt_q, cnt_n;
    logic [DWELL_W-1:0] eff_q, eff_n;
    logic               cont_q, cont_n;
    logic               stop_q, stop_n;
    logic               stop_any;

    // Channel order: rev_q selects 3->0 with step -1 (2'b11 wraps mod 4).
    logic [1:0]         first_ch, last_ch, adv, start_first;
`ifdef MUX_SCAN_REVERSE_EN
    logic               rev_q, rev_n;
    assign first_ch    = rev_q   ? 2'd3  : 2'd0;
    assign last_ch     = rev_q   ? 2'd0  : 2'd3;
    assign adv         = rev_q   ? 2'b11 : 2'b01;
    assign start_first = bus.dir ? 2'd3  : 2'd0;
`else
    assign first_ch    = 2'd0;
    assign last_ch     = 2'd3;
    assign adv         = 2'b01;
    assign start_first = 2'd0;
`endif

    always_comb begin
        state_n  = state_q;
        sel_n    = sel_q;
        data_n   = data_q;
        strobe_n = 1'b0;
        busy_n   = busy_q;
        done_n   = 1'b0;
        cnt_n    = cnt_q;
        eff_n    = eff_q;
        cont_n   = cont_q;
        stop_n   = stop_q;
        stop_any = stop_q | bus.stop;
`ifdef MUX_SCAN_REVERSE_EN
        rev_n    = rev_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_n  = SCAN;
                    eff_n    = (bus.dwell == '0) ? ONE : bus.dwell;
                    cnt_n    = eff_n - ONE;
                    cont_n   = bus.cont;
`ifdef MUX_SCAN_REVERSE_EN
                    rev_n    = bus.dir;
`endif
                    sel_n    = start_first;
                    strobe_n = 1'b1;
                    busy_n   = 1'b1;
                end
            end
            SCAN: begin
                // A stop seen on the final dwell cycle still ends this pass.
                stop_n = stop_any;
                if (cnt_q != '0) begin
                    cnt_n = cnt_q - ONE;
                end else if (sel_q != last_ch) begin
                    sel_n    = sel_q + adv;
                    data_n   = data_q + 4'd1;
                    cnt_n    = eff_q - ONE;
                    strobe_n = 1'b1;
                end else if (cont_q && !stop_any) begin
                    sel_n    = first_ch;
                    data_n   = data_q + 4'd1;
                    cnt_n    = eff_q - ONE;
                    strobe_n = 1'b1;
                end else begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
                stop_n  = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= 2'd0;
            data_q   <= 4'd0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            eff_q    <= '0;
            cont_q   <= 1'b0;
            stop_q   <= 1'b0;
`ifdef MUX_SCAN_REVERSE_EN
            rev_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_n;
            sel_q    <= sel_n;
            data_q   <= data_n;
            strobe_q <= strobe_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
            cnt_q    <= cnt_n;
            eff_q    <= eff_n;
            cont_q   <= cont_n;
            stop_q   <= stop_n;
`ifdef MUX_SCAN_REVERSE_EN
            rev_q    <= rev_n;
`endif
        end
    end

    assign bus.sel    = sel_q;
    assign bus.data   = data_q;
    assign bus.strobe = strobe_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Purpose : self-checking bench for mux_scan_ctrl against a sweep-position model.
// Latency : n/a.
// Backpr. : n/a.
module tb_mux_scan_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mux_scan_ctrl_if #(.DWELL_W(8)) bus ();
    mux_scan_ctrl #(.DWELL_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: position in a sweep is t cycles since start; channel step = t/d.
    int         m_state = 0;  // 0 idle, 1 sweeping, 2 done cycle
    int         t = 0, d = 1, base = 0;
    bit         m_cont = 0, m_stop = 0, m_rev = 0;
    logic [1:0] m_sel = 0;
    logic [3:0] m_data = 0;
    logic       m_strobe = 0, m_busy = 0, m_done = 0;

    task model_out();
        int step;
        step     = t / d;
        m_sel    = m_rev ? 2'(3 - (step % 4)) : 2'(step % 4);
        m_data   = 4'((base + step) % 16);
        m_strobe = (t % d) == 0;
        m_busy   = 1'b1;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_state = 0; m_sel = 0; m_data = 0; m_strobe = 0;
            m_busy = 0; m_done = 0; m_stop = 0; t = 0;
        end else begin
            case (m_state)
                0: begin
                    m_done = 0; m_strobe = 0;
                    if (bus.start) begin
                        d      = (bus.dwell == 0) ? 1 : int'(bus.dwell);
                        m_cont = bus.cont;
`ifdef MUX_SCAN_REVERSE_EN
                        m_rev  = bus.dir;
`else
                        m_rev  = 1'b0;
`endif
                        m_stop = 0; base = m_data; t = 0; m_state = 1;
                        model_out();
                    end
                end
                1: begin
                    if (bus.stop) m_stop = 1;
                    if ((t % (4 * d)) == 4 * d - 1 && (!m_cont || m_stop)) begin
                        m_state = 2; m_busy = 0; m_done = 1; m_strobe = 0;
                    end else begin
                        t++;
                        model_out();
                    end
                end
                default: begin
                    m_done = 0; m_stop = 0; m_state = 0;
                end
            endcase
        end
    end

    // Traces of the model, pinned below against hand-computed literals.
    int sel_trace[$];
    int busy_cnt = 0, strobe_cnt = 0, done_cnt = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle{sel,data,strobe,busy,done}",
                  int'({bus.sel, bus.data, bus.strobe, bus.busy, bus.done}),
                  int'({m_sel, m_data, m_strobe, m_busy, m_done}));
            if (m_busy) begin
                sel_trace.push_back(int'(m_sel));
                busy_cnt++;
            end
            if (m_strobe) strobe_cnt++;
            if (m_done) done_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_trace();
        sel_trace.delete();
        busy_cnt = 0; strobe_cnt = 0; done_cnt = 0;
    endtask

    task automatic check_trace(input string name, input int exp[]);
        check({name, "_len"}, sel_trace.size(), exp.size());
        for (int i = 0; i < exp.size() && i < sel_trace.size(); i++)
            check({name, "_sel"}, sel_trace[i], exp[i]);
    endtask

    task automatic pulse_start(input int dw, input bit c);
        bus.dwell = 8'(dw); bus.cont = c; bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    initial begin
        int exp8[]  = '{0, 0, 1, 1, 2, 2, 3, 3};
        int exp4[]  = '{0, 1, 2, 3};
        int exp2p[] = '{0, 1, 2, 3, 0, 1, 2, 3};
        bus.start = 0; bus.cont = 0; bus.stop = 0; bus.dwell = 0;
`ifdef MUX_SCAN_REVERSE_EN
        bus.dir = 0;
`endif
        tick(1);
        chk_en = 1'b1;
        tick(1);
        rst = 1'b0;
        check("reset_outputs",
              int'({bus.sel, bus.data, bus.strobe, bus.busy, bus.done}), 0);

        // Single sweep, dwell 2.
        clear_trace();
        pulse_start(2, 0);
        tick(11);
        check_trace("dw2", exp8);
        check("dw2_busy", busy_cnt, 8);
        check("dw2_strobe", strobe_cnt, 4);
        check("dw2_done", done_cnt, 1);
        check("dw2_data", int'(bus.data), 3);

        // dwell 0 behaves as dwell 1; data continues from 3.
        clear_trace();
        pulse_start(0, 0);
        tick(7);
        check_trace("dw0", exp4);
        check("dw0_busy", busy_cnt, 4);
        check("dw0_data", int'(bus.data), 6);

        // Continuous, stop during cycle 6 -> two full passes.
        rst = 1'b1; tick(1); rst = 1'b0;
        clear_trace();
        pulse_start(1, 1);
        tick(5);
        bus.stop = 1'b1; tick(1); bus.stop = 1'b0;
        tick(8);
        check_trace("cont", exp2p);
        check("cont_done", done_cnt, 1);
        check("cont_data", int'(bus.data), 7);

        // Start during busy ignored; reset mid-dwell on channel 2 overrides start.
        clear_trace();
        pulse_start(3, 0);
        tick(2);
        bus.start = 1'b1; tick(1); bus.start = 1'b0;
        tick(4);
        check("mid_sel", int'(bus.sel), 2);
        check("mid_busy", int'(bus.busy), 1);
        rst = 1'b1; bus.start = 1'b1;
        tick(1);
        rst = 1'b0; bus.start = 1'b0;
        check("rst_mid_outputs",
              int'({bus.sel, bus.data, bus.strobe, bus.busy, bus.done}), 0);
        tick(3);
        check("rst_no_restart", int'(bus.busy), 0);

        // 20 channel steps in continuous mode: data wraps 15 -> 0 at step 16.
        clear_trace();
        pulse_start(1, 1);
        tick(15);
        check("wrap_d15", int'(bus.data), 15);
        check("wrap_s15", int'(bus.sel), 3);
        tick(1);
        check("wrap_d16", int'(bus.data), 0);
        check("wrap_s16", int'(bus.sel), 0);
        tick(3);
        check("wrap_d19", int'(bus.data), 3);
        bus.stop = 1'b1; tick(1); bus.stop = 1'b0;
        tick(3);
        check("wrap_busy", busy_cnt, 20);
        check("wrap_done", done_cnt, 1);

`ifdef MUX_SCAN_REVERSE_EN
        begin
            int expr[] = '{3, 2, 1, 0};
            clear_trace();
            bus.dir = 1'b1;
            pulse_start(1, 0);
            bus.dir = 1'b0;
            tick(6);
            check_trace("rev", expr);
            check("rev_done", done_cnt, 1);
        end
`endif

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter DWELL_W, default 8, width of dwell count and dwell input.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  begin a sweep; sampled only in IDLE.
REQ-005 cont  input  1  continuous-sweep request; sampled with start.
REQ-006 stop  input  1  end continuous sweep after the current pass; sampled every SCAN cycle.
REQ-007 dwell  input  DWELL_W  cycles per channel; sampled with start.
REQ-008 sel  output  2  channel select to downstream mux bank, registered.
REQ-009 data  output  4, indexed [5:2]  step tag to downstream data port, registered.
REQ-010 strobe  output  1  one-cycle pulse on each new sel value.
REQ-011 busy  output  1  high while sweeping.
REQ-012 done  output  1  one-cycle pulse at sweep end.

Function
REQ-013 FSM states SHALL be IDLE, SCAN and DONE only.
REQ-014 IDLE with start=1 -> SCAN next edge: sel=first channel, strobe=1, busy=1, data unchanged, dwell_eff latched, cnt=dwell_eff-1, cont latched.
REQ-015 dwell_eff SHALL be dwell, or 1 when dwell=0.
REQ-016 SCAN, cnt!=0: cnt decrements; sel and data hold; strobe=0.
REQ-017 SCAN, cnt=0, not last channel: sel advances one, data increments, cnt reloads dwell_eff-1, strobe=1.
REQ-018 SCAN, cnt=0, last channel, latched cont=1 and no pending stop: sel wraps to first channel, data increments, cnt reloads, strobe=1.
REQ-019 SCAN, cnt=0, last channel, cont=0 or stop pending: -> DONE; sel and data hold.
REQ-020 stop=1 on any SCAN cycle SHALL set a sticky stop-pending flag, cleared on leaving DONE.
REQ-021 DONE: done=1, busy=0 for exactly one cycle; then -> IDLE.
REQ-022 Single sweep SHALL keep busy high for exactly 4*dwell_eff cycles.
REQ-023 data SHALL wrap 15 -> 0 with no flag.
REQ-024 start while in SCAN or DONE SHALL be ignored; start on the IDLE cycle right after DONE SHALL begin a new sweep.
REQ-025 Default order: first channel 0, last channel 3, advance = +1.

Reset
REQ-026 rst=1 on a clock edge SHALL force IDLE, sel=0, data=0, strobe=0, busy=0, done=0, cnt=0, stop-pending=0, from any state, mid-sweep included.
REQ-027 rst SHALL override start in the same cycle.

Configuration
REQ-028 Macro MUX_SCAN_REVERSE_EN, when defined, SHALL add input dir (1 bit, sampled with start); dir=1 gives first channel 3, last channel 0, advance = -1; dir=0 gives default order.
REQ-029 Without MUX_SCAN_REVERSE_EN the dir port SHALL NOT exist and order SHALL be per REQ-025.

Verification
REQ-030 Reset, then start=1, dwell=2, cont=0 -> sel 0,0,1,1,2,2,3,3; strobe on cycles 1,3,5,7; data 0,1,2,3; done one cycle after last sel=3; busy 8 cycles.
REQ-031 start with dwell=0 -> behaves as dwell=1: sel 0,1,2,3 on consecutive cycles, busy 4 cycles.
REQ-032 cont=1, dwell=1, stop=1 at cycle 6 -> second pass completes (sel 0..3 twice), done once, data ends at 7.
REQ-033 rst=1 while sel=2 mid-dwell -> next cycle all outputs 0, state IDLE; start pulse during busy produces no restart.
REQ-034 cont=1 run of 20 channel steps -> data wraps 15 -> 0 at step 16, sel cycles 0..3.
REQ-035 With MUX_SCAN_REVERSE_EN, dir=1, dwell=1 -> sel 3,2,1,0 then done.
